// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-sub slice, LSB first.
// Ports: clk, rst_n, start/op/a/b in; busy/done/result/cout (+ovf if SERIAL_ADD_SUB_OVF_EN) out.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             c_q;
  logic             c_d;
  logic             d_bit;
  logic             ai;
  logic             bi;
  logic             last;
  logic             accept;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf_q;
`endif

  always_comb begin
    ai     = a_q[0];
    bi     = b_q[0];
    d_bit  = ai ^ bi ^ c_q;
    // Borrow form for subtract, carry form for add.
    c_d    = op_q ? ((~ai & bi) | (~(ai ^ bi) & c_q))
                  : ((ai & bi) | (c_q & (ai ^ bi)));
    acc_d  = {d_bit, acc_q[WIDTH-1:1]};
    last   = (cnt_q == CW'(WIDTH - 1));
    accept = start && (state_q != S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= S_RUN;
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          acc_q <= acc_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q  <= S_DONE;
            result_q <= acc_d;
            cout_q   <= c_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
            // Carry into MSB differs from carry out of MSB.
            ovf_q    <= c_q ^ c_d;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8).
// Vector table, handshake corner sequences, random ops vs arithmetic model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output logic [W-1:0] r,
                       output logic c, output logic v);
    int ux, uy, s;
    int sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    if (o) begin
      s  = ux - uy;
      c  = (ux < uy);
      sr = sx - sy;
    end else begin
      s  = ux + uy;
      c  = (s >= (1 << W));
      sr = sx + sy;
    end
    r = s[W-1:0];
    v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  // Start one op, check busy length, done latency and results.
  task automatic run_op(input string nm, input logic o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ec,
                        input logic ev);
    int cyc, bcnt, both;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cyc  = 0;
    bcnt = 0;
    both = 0;
    while (!done && cyc < W + 4) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, ".lat"}, cyc, W);
    chk({nm, ".busy_len"}, bcnt, W);
    chk({nm, ".busy_at_done"}, {31'd0, busy}, 0);
    chk({nm, ".result"}, {24'd0, result}, {24'd0, er});
    chk({nm, ".cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, ev});
`else
    if (ev === 1'bx) $display("unexpected x ovf");
`endif
    @(negedge clk);
    chk({nm, ".done_drop"}, {31'd0, done}, 0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           dcnt;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         ro;

    vecs.push_back('{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0});

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.done", {31'd0, done}, 0);
    chk("rst.result", {24'd0, result}, 0);
    chk("rst.cout", {31'd0, cout}, 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk("rst.ovf", {31'd0, ovf}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].r, vecs[i].c, vecs[i].v);

    // start held during RUN is ignored; start in DONE restarts.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 8'h5A;
    b     = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 8'hFF;
    b     = 8'hFE;
    repeat (5) @(negedge clk);
    op = 1'b0;
    a  = 8'h01;
    b  = 8'h02;
    @(negedge clk);
    chk("b2b.first_done", {31'd0, done}, 1);
    chk("b2b.first_result", {24'd0, result}, 8'h96);
    chk("b2b.first_cout", {31'd0, cout}, 0);
    @(negedge clk);
    start = 1'b0;
    a     = 8'hAA;
    b     = 8'h77;
    chk("b2b.restart_busy", {31'd0, busy}, 1);
    chk("b2b.restart_done", {31'd0, done}, 0);
    repeat (7) @(negedge clk);
    chk("b2b.pre_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("b2b.second_done", {31'd0, done}, 1);
    chk("b2b.second_result", {24'd0, result}, 8'h03);
    chk("b2b.second_cout", {31'd0, cout}, 0);

    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || result !== 8'h03) dcnt++;
    end
    chk("hold.idle20", dcnt, 0);

    // Reset mid-run abandons the operation.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", {31'd0, busy}, 0);
    chk("mid_rst.result", {24'd0, result}, 0);
    chk("mid_rst.cout", {31'd0, cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || result !== 8'h00) dcnt++;
    end
    chk("mid_rst.quiet", dcnt, 0);
    run_op("post_rst", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      model(ro, rx, ry, r, c, v);
      run_op($sformatf("rnd%0d", i), ro, rx, ry, r, c, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor with a start/done handshake, the sequential counterpart to our combinational half/full subtractor cells. The block latches two WIDTH-bit operands and an operation select, processes one bit per clock LSB-first through a single full-adder/full-subtractor slice with a carry/borrow flop, and presents the registered result and carry/borrow out. It is used where area matters more than latency, and its bit-slice equations must match our existing combinational adder and subtractor cells.

## Interface
- WIDTH, 8: operand and result width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE and DONE.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start.
- a  input  WIDTH  minuend/addend; latched with start.
- b  input  WIDTH  subtrahend/addend; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result/cout update.
- result  output  WIDTH  last completed sum/difference; held between operations.
- cout  output  1  add: carry out; sub: borrow out (1 iff a < b unsigned).
- ovf  output  1  signed overflow; present only when SERIAL_ADD_SUB_OVF_EN is defined.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit steps.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Accept: at the start edge, load a and b into shift registers, latch op, clear the carry/borrow flop, clear the bit counter, and clear the internal accumulator shift register.
- Each RUN edge processes bit i = counter:
  - Sum/difference bit d = a_i ^ b_i ^ c.
  - Add: c' = a_i&b_i | c&(a_i^b_i).
  - Sub: c' = ~a_i&b_i | ~(a_i^b_i)&c.
  - d shifts into the accumulator MSB, the operand registers shift right, and the counter increments.
- Final step (counter = WIDTH-1): copy the accumulator (including this bit) to result and the final c' to cout, then enter DONE.
- All arithmetic is modulo 2^WIDTH. Operands are unsigned for cout; ovf treats them as two's complement.
- start during RUN is ignored; operands changing during RUN have no effect.
- result/cout/ovf change only on the DONE-entry edge or on reset.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, state IDLE, counter 0.
- Reset mid-RUN abandons the operation; result keeps its reset value 0 rather than any partial value.
- start captured at edge k:
  - busy=1 from after k through after edge k+WIDTH-1.
  - At edge k+WIDTH: busy=0, done=1, result/cout valid.
  - At edge k+WIDTH+1: done=0, unless restarted.
- Latency: WIDTH cycles from the accepting edge to done.
- Throughput: start held high during DONE is accepted on that edge, giving one operation per WIDTH+1 cycles. done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_OVF_EN defined:
  - Adds the ovf port and register.
  - ovf = c_in_msb ^ c_out_msb, where these are the carry/borrow into and out of the MSB step. Equivalently, ovf is set when the signed result sign is wrong for the operand signs.
  - ovf updates with result and resets to 0.
- SERIAL_ADD_SUB_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, op=0, a=0x5A, b=0x3C, start at edge k -> done pulse exactly at k+8, result=0x96, cout=0, busy high for 8 cycles.
- op=0, a=0xFF, b=0x01 -> result=0x00, cout=1. Then op=1, a=0x10, b=0x20 -> result=0xF0, cout=1. Then op=1, a=0x33, b=0x33 -> result=0x00, cout=0.
- Hold start=1 with new operands during RUN at cycle k+3 -> ignored, first result unchanged. Hold start=1 in the DONE cycle with a=0x01, b=0x02, op=0 -> second done at k+17, result=0x03.
- Change a/b mid-RUN -> result reflects the latched values only. result holds 0x03 through 20 idle cycles.
- Assert rst_n=0 at cycle k+4 of a run -> outputs return to reset values immediately, no done pulse. After release, a fresh op=1, a=0x00, b=0x01 -> result=0xFF, cout=1.
- With SERIAL_ADD_SUB_OVF_EN:
  - op=0, 0x7F+0x01 -> result 0x80, ovf=1.
  - op=1, 0x80-0x01 -> result 0x7F, ovf=1.
  - op=0, 0x05+0x03 -> result 0x08, ovf=0.
